// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer: game-state encodings, the
// default preload mask built from them, and the per-channel count ceiling.
// Imported by sound_seq and sound_tick_gen.
package sound_pkg;

   // Game-state encodings as driven by the game FSM.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_MUTE_A = 3'b001,
      ST_MUTE_B = 3'b100,
      ST_MUTE_C = 3'b101
   } game_state_e;

   // States whose restart should leave the sound suppressed (count loaded
   // at MAX). ST_IDLE is deliberately absent: restarting from idle replays.
   localparam logic [7:0] PRELOAD_MASK_DEF = (8'd1 << ST_MUTE_A)
                                           | (8'd1 << ST_MUTE_B)
                                           | (8'd1 << ST_MUTE_C);

   // Largest value a CNT_W-bit counter holds.
   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/sound_seq_if.sv
// Bundle between the game side and the sound sequencer.
// master: game FSM / audio glue (drives state, restart, aout; sees counts).
// slave : sound_seq (samples inputs, drives cnt, busy, tick and optional done).
// Optional done[] wires exist only when SOUND_SEQ_DONE_EN is defined.
interface sound_seq_if #(
   parameter int CH      = 2,
   parameter int CNT_W   = 2,
   parameter int STATE_W = 3
);

   logic [STATE_W-1:0]  state;
   logic                restart;
   logic [CH-1:0]       aout;
   logic [CH*CNT_W-1:0] cnt;
   logic [CH-1:0]       busy;
   logic                tick;
`ifdef SOUND_SEQ_DONE_EN
   logic [CH-1:0]       done;
`endif

   modport master (
      output state, restart, aout,
`ifdef SOUND_SEQ_DONE_EN
      input  done,
`endif
      input  cnt, busy, tick
   );

   modport slave (
      input  state, restart, aout,
`ifdef SOUND_SEQ_DONE_EN
      output done,
`endif
      output cnt, busy, tick
   );

endinterface

// File: rtl/sound_tick_gen.sv
// Purpose : free-running prescaler producing the sample strobe for sound_seq.
// Latency : registered; tick is high in the cycle the prescaler is TICK_DIV-1,
//           i.e. the TICK_DIV-th cycle after RST falls, then every TICK_DIV.
// Backpressure: none; free-running, only RST restarts the count.
// Ports: CLK, RST (sync, active-high), tick (one-cycle strobe).
module sound_tick_gen
   import sound_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic CLK,
   input  logic RST,
   output logic tick
);

   localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_nxt;

   always_comb begin
      pre_nxt = (pre_q == LAST) ? '0 : pre_q + 1'b1;
   end

   // tick is registered from the *next* prescaler value so that it is high
   // exactly while pre_q == LAST, without a combinational output path.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pre_q <= '0;
         tick  <= 1'b0;
      end else begin
         pre_q <= pre_nxt;
         tick  <= (pre_nxt == LAST);
      end
   end

endmodule

// File: rtl/sound_seq.sv
// Purpose : per-channel counter of completed audio playbacks, preloaded from
//           the game state on restart; sits between game FSM and players.
// Latency : cnt/busy (and done) update one cycle after the tick cycle;
//           restart takes effect the cycle after it is sampled.
// Backpressure: none; aout is sampled only at ticks, short pulses may be missed.
// Ports: CLK, RST (sync, active-high), bus (sound_seq_if.slave):
//        state, restart, aout in; cnt[CH*CNT_W], busy[CH], tick out.
// Build option: SOUND_SEQ_DONE_EN adds done[CH], a one-cycle pulse when a
//        channel reaches MAX by counting (not by preload or saturated hold).
module sound_seq
   import sound_pkg::*;
#(
   parameter int                          CH           = 2,
   parameter int                          CNT_W        = 2,
   parameter int                          STATE_W      = 3,
   parameter logic [(1<<STATE_W)-1:0]     PRELOAD_MASK = PRELOAD_MASK_DEF,
   parameter int                          TICK_DIV     = 50000,
   parameter bit                          WRAP         = 1'b0
) (
   input  logic     CLK,
   input  logic     RST,
   sound_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

   logic               tick;
   logic [CNT_W-1:0]   pre_val;
   logic [CH*CNT_W-1:0] cnt_flat;
   logic [CH-1:0]      busy_v;
`ifdef SOUND_SEQ_DONE_EN
   logic [CH-1:0]      done_v;
`endif

   sound_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick)
   );

   // Value every channel takes while restart is held.
   always_comb begin
      pre_val = PRELOAD_MASK[bus.state] ? MAX : '0;
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      // armed: aout was seen low at a tick (or restart/reset happened) since
      // the last counted edge, so the next high sample counts once.
      logic             armed_q;

      always_ff @(posedge CLK) begin
         if (RST) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
         end else if (bus.restart) begin
            cnt_q   <= pre_val;
            armed_q <= 1'b1;
         end else if (tick) begin
            if (!bus.aout[i]) begin
               armed_q <= 1'b1;
            end else if (armed_q) begin
               armed_q <= 1'b0;
               if (cnt_q != MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end else if (WRAP) begin
                  cnt_q <= '0;
               end
            end
         end
      end

      assign cnt_flat[i*CNT_W +: CNT_W] = cnt_q;
      assign busy_v[i]                  = (cnt_q != MAX);

`ifdef SOUND_SEQ_DONE_EN
      // Counted edge this cycle; MAX-1 -> MAX is the only increment that
      // lands on MAX, so preloads and saturated holds never pulse.
      logic hit;
      logic done_q;

      assign hit = tick && !bus.restart && bus.aout[i] && armed_q;

      always_ff @(posedge CLK) begin
         if (RST) begin
            done_q <= 1'b0;
         end else begin
            done_q <= hit && (cnt_q == MAX - 1'b1);
         end
      end

      assign done_v[i] = done_q;
`endif
   end

   assign bus.cnt  = cnt_flat;
   assign bus.busy = busy_v;
   assign bus.tick = tick;
`ifdef SOUND_SEQ_DONE_EN
   assign bus.done = done_v;
`endif

endmodule

// File: tb/tb_sound_seq.sv
// Bench for sound_seq: two instances (saturating and wrapping) share CLK,
// RST and stimulus; a behavioural episode model predicts counts and ticks.
module tb_sound_seq;

   localparam int CH    = 2;
   localparam int CNT_W = 2;
   localparam int TD    = 4;
   localparam int MAX   = 3;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [2:0]    st  = '0;
   logic          rs  = 1'b0;
   logic [CH-1:0] ao  = '0;

   bit [7:0] mask = 8'b0011_0010;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   sound_seq_if #(.CH(CH), .CNT_W(CNT_W), .STATE_W(3)) ifa ();
   sound_seq_if #(.CH(CH), .CNT_W(CNT_W), .STATE_W(3)) ifb ();

   assign ifa.state = st;  assign ifa.restart = rs;  assign ifa.aout = ao;
   assign ifb.state = st;  assign ifb.restart = rs;  assign ifb.aout = ao;

   sound_seq #(.CH(CH), .CNT_W(CNT_W), .STATE_W(3), .TICK_DIV(TD), .WRAP(1'b0))
      dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
   sound_seq #(.CH(CH), .CNT_W(CNT_W), .STATE_W(3), .TICK_DIV(TD), .WRAP(1'b1))
      dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));

   // ---------------- reference model ----------------
   // hi[c]: the current high episode on channel c has already been counted.
   typedef struct {
      int cnt  [CH];
      bit hi   [CH];
      bit done [CH];
   } mdl_t;

   mdl_t m0, m1;
   int   m_cyc  = 0;
   bit   m_tick = 1'b0;

   function automatic mdl_t mdl_next(mdl_t s, bit wrap, bit tk, bit rst_in,
                                     bit rst_lvl, bit [2:0] sv, bit [CH-1:0] a);
      mdl_t n = s;
      for (int c = 0; c < CH; c++) begin
         n.done[c] = 1'b0;
         if (rst_in) begin
            n.cnt[c] = 0;  n.hi[c] = 1'b0;
         end else if (rst_lvl) begin
            n.cnt[c] = mask[sv] ? MAX : 0;  n.hi[c] = 1'b0;
         end else if (tk && !a[c]) begin
            n.hi[c] = 1'b0;
         end else if (tk && a[c] && !s.hi[c]) begin
            n.hi[c] = 1'b1;
            if (s.cnt[c] < MAX) begin
               n.cnt[c]  = s.cnt[c] + 1;
               n.done[c] = (n.cnt[c] == MAX);
            end else if (wrap) begin
               n.cnt[c] = 0;
            end
         end
      end
      return n;
   endfunction

   always @(posedge CLK) begin
      m0 <= mdl_next(m0, 1'b0, m_tick, RST, rs, st, ao);
      m1 <= mdl_next(m1, 1'b1, m_tick, RST, rs, st, ao);
      if (RST) begin
         m_cyc  <= 0;
         m_tick <= 1'b0;
      end else begin
         m_cyc  <= m_cyc + 1;
         m_tick <= ((m_cyc + 1) % TD) == (TD - 1);
      end
   end

`ifdef SOUND_SEQ_DONE_EN
   int done_b1_cnt = 0;
   always @(negedge CLK) if (ifb.done[1] === 1'b1) done_b1_cnt <= done_b1_cnt + 1;
`endif

   function automatic int cnt_of(bit d, int c);
      return d ? int'(ifb.cnt[c*CNT_W +: CNT_W]) : int'(ifa.cnt[c*CNT_W +: CNT_W]);
   endfunction

   // Advance to a negedge inside a tick cycle (bounded by model cycles).
   task automatic to_tick();
      int n = 0;
      @(negedge CLK);
      while (m_tick !== 1'b1 && n < 2*TD) begin
         @(negedge CLK);
         n++;
      end
   endtask

   // Present aout during a tick cycle; return where the result is visible.
   task automatic apply_at_tick(input logic [CH-1:0] a);
      to_tick();
      ao = a;
      @(negedge CLK);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST = 1'b1; rs = 1'b0; ao = '0; st = '0;
      repeat (2) @(negedge CLK);
      checks++; if (ifa.cnt !== 4'b0000 || ifb.cnt !== 4'b0000) begin errors++;
         $display("FAIL reset_cnt: got a=%b b=%b expected 0000", ifa.cnt, ifb.cnt); end
      checks++; if (ifa.busy !== 2'b11 || ifb.busy !== 2'b11) begin errors++;
         $display("FAIL reset_busy: got a=%b b=%b expected 11", ifa.busy, ifb.busy); end
`ifdef SOUND_SEQ_DONE_EN
      checks++; if (ifa.done !== 2'b00) begin errors++;
         $display("FAIL reset_done: got %b expected 00", ifa.done); end
`endif
      RST = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge CLK);
         checks++; if (ifa.tick !== (k % TD == 0) || ifb.tick !== (k % TD == 0)) begin errors++;
            $display("FAIL tick_cycle%0d: got a=%b b=%b expected %0d", k, ifa.tick, ifb.tick, k % TD == 0); end
      end
   endtask

   task automatic test_saturate();
      int exp_a[5] = '{1, 2, 3, 3, 3};
      int exp_b[5] = '{1, 2, 3, 0, 1};
      for (int e = 0; e < 5; e++) begin
         apply_at_tick(2'b01);
         checks++; if (cnt_of(0, 0) !== exp_a[e] || cnt_of(1, 0) !== exp_b[e]) begin errors++;
            $display("FAIL sat_edge%0d: got a=%0d b=%0d expected a=%0d b=%0d", e, cnt_of(0,0), cnt_of(1,0), exp_a[e], exp_b[e]); end
         checks++; if (ifa.busy[0] !== (e < 2) || cnt_of(0, 1) !== 0) begin errors++;
            $display("FAIL sat_busy_ch1_%0d: got busy0=%b cnt1=%0d expected %0d,0", e, ifa.busy[0], cnt_of(0,1), e < 2); end
`ifdef SOUND_SEQ_DONE_EN
         checks++; if (ifa.done[0] !== (e == 2) || ifb.done[0] !== (e == 2)) begin errors++;
            $display("FAIL sat_done%0d: got a=%b b=%b expected %0d", e, ifa.done[0], ifb.done[0], e == 2); end
`endif
         apply_at_tick(2'b01);
         checks++; if (cnt_of(0, 0) !== exp_a[e]) begin errors++;
            $display("FAIL sat_hold%0d: got %0d expected %0d", e, cnt_of(0,0), exp_a[e]); end
         apply_at_tick(2'b00);
         apply_at_tick(2'b00);
      end
   endtask

   task automatic test_preload();
      rs = 1'b1; st = 3'b100;
      @(negedge CLK);
      checks++; if (ifa.cnt !== 4'b1111 || ifb.cnt !== 4'b1111 || ifa.busy !== 2'b00) begin errors++;
         $display("FAIL preload_set: got a=%b b=%b busy=%b expected 1111,1111,00", ifa.cnt, ifb.cnt, ifa.busy); end
`ifdef SOUND_SEQ_DONE_EN
      checks++; if (ifa.done !== 2'b00 || ifb.done !== 2'b00) begin errors++;
         $display("FAIL preload_nodone: got a=%b b=%b expected 00", ifa.done, ifb.done); end
`endif
      st = 3'b010;
      @(negedge CLK);
      checks++; if (ifa.cnt !== 4'b0000 || ifb.cnt !== 4'b0000 || ifb.busy !== 2'b11) begin errors++;
         $display("FAIL preload_clr: got a=%b b=%b busy=%b expected 0000,0000,11", ifa.cnt, ifb.cnt, ifb.busy); end
      st = 3'b101;
      apply_at_tick(2'b11);
      checks++; if (ifa.cnt !== 4'b1111 || ifb.cnt !== 4'b1111) begin errors++;
         $display("FAIL preload_hold: got a=%b b=%b expected 1111", ifa.cnt, ifb.cnt); end
      rs = 1'b0; ao = '0; st = '0;
   endtask

   task automatic test_priority();
      to_tick();
      rs = 1'b1; st = 3'b000; ao = 2'b11;
      @(negedge CLK);
      checks++; if (ifa.cnt !== 4'b0000 || ifb.cnt !== 4'b0000) begin errors++;
         $display("FAIL prio_restart_tick: got a=%b b=%b expected 0000", ifa.cnt, ifb.cnt); end
      rs = 1'b0;
      apply_at_tick(2'b11);
      checks++; if (ifa.cnt !== 4'b0101 || ifb.cnt !== 4'b0101) begin errors++;
         $display("FAIL prio_armed: got a=%b b=%b expected 0101", ifa.cnt, ifb.cnt); end
      rs = 1'b1; st = 3'b100; RST = 1'b1;
      @(negedge CLK);
      checks++; if (ifa.cnt !== 4'b0000 || ifb.cnt !== 4'b0000 || ifa.tick !== 1'b0) begin errors++;
         $display("FAIL prio_rst: got a=%b b=%b tick=%b expected 0000,0000,0", ifa.cnt, ifb.cnt, ifa.tick); end
      RST = 1'b0; rs = 1'b0; ao = '0; st = '0;
   endtask

   task automatic test_wrap();
      int exp_b[4] = '{1, 2, 3, 0};
      int exp_a[4] = '{1, 2, 3, 3};
`ifdef SOUND_SEQ_DONE_EN
      @(negedge CLK); #1;
      done_b1_cnt = 0;
`endif
      for (int e = 0; e < 4; e++) begin
         apply_at_tick(2'b10);
         checks++; if (cnt_of(1, 1) !== exp_b[e] || cnt_of(0, 1) !== exp_a[e] || cnt_of(1, 0) !== 0) begin errors++;
            $display("FAIL wrap_edge%0d: got b1=%0d a1=%0d b0=%0d expected %0d,%0d,0", e, cnt_of(1,1), cnt_of(0,1), cnt_of(1,0), exp_b[e], exp_a[e]); end
         apply_at_tick(2'b00);
      end
`ifdef SOUND_SEQ_DONE_EN
      @(negedge CLK); #1;
      checks++; if (done_b1_cnt !== 1) begin errors++;
         $display("FAIL wrap_done_count: got %0d expected 1", done_b1_cnt); end
`endif
   endtask

   task automatic test_held();
      rs = 1'b1; st = 3'b000;
      @(negedge CLK);
      rs = 1'b0;
      for (int t = 0; t < 10; t++) begin
         apply_at_tick(2'b10);
         checks++; if (cnt_of(0, 1) !== 1 || cnt_of(1, 1) !== 1 || cnt_of(0, 0) !== 0) begin errors++;
            $display("FAIL held_tick%0d: got a1=%0d b1=%0d a0=%0d expected 1,1,0", t, cnt_of(0,1), cnt_of(1,1), cnt_of(0,0)); end
      end
      apply_at_tick(2'b00);
      checks++; if (cnt_of(0, 1) !== 1) begin errors++;
         $display("FAIL held_low: got %0d expected 1", cnt_of(0,1)); end
      apply_at_tick(2'b10);
      checks++; if (cnt_of(0, 1) !== 2 || cnt_of(1, 1) !== 2) begin errors++;
         $display("FAIL held_rearm: got a1=%0d b1=%0d expected 2", cnt_of(0,1), cnt_of(1,1)); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         @(negedge CLK);
         checks++; if (ifa.tick !== m_tick || ifb.tick !== m_tick) begin errors++;
            $display("FAIL rnd_tick%0d: got a=%b b=%b expected %b", i, ifa.tick, ifb.tick, m_tick); end
         for (int c = 0; c < CH; c++) begin
            checks++; if (cnt_of(0, c) !== m0.cnt[c] || cnt_of(1, c) !== m1.cnt[c]) begin errors++;
               $display("FAIL rnd_cnt%0d_ch%0d: got a=%0d b=%0d expected a=%0d b=%0d", i, c, cnt_of(0,c), cnt_of(1,c), m0.cnt[c], m1.cnt[c]); end
            checks++; if (ifa.busy[c] !== (m0.cnt[c] != MAX) || ifb.busy[c] !== (m1.cnt[c] != MAX)) begin errors++;
               $display("FAIL rnd_busy%0d_ch%0d: got a=%b b=%b expected a=%0d b=%0d", i, c, ifa.busy[c], ifb.busy[c], m0.cnt[c] != MAX, m1.cnt[c] != MAX); end
`ifdef SOUND_SEQ_DONE_EN
            checks++; if (ifa.done[c] !== m0.done[c] || ifb.done[c] !== m1.done[c]) begin errors++;
               $display("FAIL rnd_done%0d_ch%0d: got a=%b b=%b expected a=%b b=%b", i, c, ifa.done[c], ifb.done[c], m0.done[c], m1.done[c]); end
`endif
         end
         rs = ($urandom_range(0, 39) == 0);
         st = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) ao = CH'($urandom);
      end
      rs = 1'b0; ao = '0;
   endtask

   initial begin
      test_reset();
      test_saturate();
      test_preload();
      test_priority();
      test_wrap();
      test_held();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
